// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising XNOR-LFSR PRBS checker with lock tracking and saturating BER counters.
module prbs_checker #(
  parameter int n          = 16,
  parameter int LOCK_CNT   = 64,
  parameter int WIN        = 256,
  parameter int UNLOCK_ERR = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cke,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0;
    endcase
  endfunction
  if (tap_mask(n) == 32'h0) begin : g_bad_width
    $error("prbs_checker: no LFSR tap entry for n=%0d", n);
  end
  localparam int FW = $clog2(n);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN + 1);
  localparam int EW = $clog2(UNLOCK_ERR + 1);
  localparam logic [n-1:0]  MASK   = n'(tap_mask(n));
  localparam logic [FW-1:0] F_LAST = FW'(n - 1);
  localparam logic [MW-1:0] M_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WIN - 1);
  localparam logic [EW-1:0] E_LIM  = EW'(UNLOCK_ERR);
  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;
  state_t           r_state, w_state;
  logic [n-1:0]     r_s, w_s;
  logic [FW-1:0]    r_fill, w_fill;
  logic [MW-1:0]    r_match, w_match;
  logic [WW-1:0]    r_wbit, w_wbit;
  logic [EW-1:0]    r_werr, w_werr, w_werr_acc;
  logic [CNT_W-1:0] r_errc, w_errc, r_bitc, w_bitc;
  logic             r_err, w_err, r_locked, w_p, w_miss;
  assign w_p        = ~^(r_s & MASK);
  assign w_miss     = din != w_p;
  assign w_werr_acc = r_werr + EW'(w_miss);
  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_fill  = r_fill;
    w_match = r_match;
    w_wbit  = r_wbit;
    w_werr  = r_werr;
    w_errc  = r_errc;
    w_bitc  = r_bitc;
    w_err   = 1'b0;
    if (cke) begin
      case (r_state)
        SEED: begin
          w_s    = {r_s[n-2:0], din};
          w_fill = (r_fill == F_LAST) ? '0 : r_fill + 1'b1;
          // An all-ones fill is the XNOR lockup state and can never predict a live stream.
          if (r_fill == F_LAST && w_s != '1) begin
            w_state = VERIFY;
            w_match = '0;
          end
        end
        VERIFY: begin
          w_s     = {r_s[n-2:0], din};
          w_match = r_match + 1'b1;
          if (w_miss) begin
            w_state = SEED;
            w_fill  = '0;
          end else if (r_match == M_LAST) begin
            w_state = LOCKED;
            w_wbit  = '0;
            w_werr  = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a received error does not corrupt the shadow.
          w_s    = {r_s[n-2:0], w_p};
          w_err  = w_miss;
          w_bitc = (r_bitc == '1) ? r_bitc : r_bitc + 1'b1;
          w_errc = (w_miss && r_errc != '1) ? r_errc + 1'b1 : r_errc;
          w_wbit = (r_wbit == W_LAST) ? '0 : r_wbit + 1'b1;
          w_werr = (r_wbit == W_LAST) ? '0 : w_werr_acc;
          if (w_werr_acc == E_LIM) begin
            w_state = SEED;
            w_fill  = '0;
          end
        end
        default: w_state = SEED;
      endcase
    end
    if (clr) begin
      w_errc = '0;
      w_bitc = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SEED;
      r_s      <= '0;
      r_fill   <= '0;
      r_match  <= '0;
      r_wbit   <= '0;
      r_werr   <= '0;
      r_errc   <= '0;
      r_bitc   <= '0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_s      <= w_s;
      r_fill   <= w_fill;
      r_match  <= w_match;
      r_wbit   <= w_wbit;
      r_werr   <= w_werr;
      r_errc   <= w_errc;
      r_bitc   <= w_bitc;
      r_err    <= w_err;
      r_locked <= w_state == LOCKED;
    end
  end
  assign locked    = r_locked;
  assign err       = r_err;
  assign err_count = r_errc;
  assign bit_count = r_bitc;
endmodule
